timer_entry: RTL and testbench
==============================

Name: timer_entry

Overview:
- Operator front-end directly upstream of the egg-timer BCD countdown counter.
- Debounces the select, increment, start/pause and clear push-buttons, and builds the preset time as four BCD digits on a1..d1.
- Drives the counter's load and str inputs through a set/run/pause/done state machine.
- Consumes the counter's dn flag to raise the alarm and to request a dn clear.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button level is accepted (10 ms at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_sel  in  1  raw button: advance selected digit.
- btn_inc  in  1  raw button: increment selected digit.
- btn_start  in  1  raw button: start / pause / resume.
- btn_clr  in  1  raw button: clear / abort / acknowledge.
- dn  in  1  done flag from countdown counter.
- a1  out  4  preset seconds-ones BCD, range 0-9.
- b1  out  4  preset seconds-tens BCD, range 0-5.
- c1  out  4  preset minutes-ones BCD, range 0-9.
- d1  out  4  preset minutes-tens BCD, range 0-9.
- sel  out  2  selected digit: 0=a1, 1=b1, 2=c1, 3=d1.
- load  out  1  counter load request; high exactly while in SET.
- str  out  1  counter run enable; high exactly while in RUN.
- alarm  out  1  high exactly while in DONE.
- dn_clr  out  1  one-cycle pulse requesting the counter clear its dn flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=SET; a1=b1=c1=d1=0; sel=0.
  - str=0, alarm=0, dn_clr=0; load=1 (decoded from SET).
  - Debouncer state cleared: stable level 0, counters 0.
- Input conditioning, per button:
  - 2-FF synchroniser, then debounce counter.
  - Counter increments while synced level != stable level and clears otherwise.
  - When counter reaches DEBOUNCE_CYCLES-1, stable level takes the synced level and counter clears.
  - Press event = one-cycle pulse on a stable 0->1 transition; release produces no event.
  - Latency from raw edge to event is DEBOUNCE_CYCLES+2 cycles, ±1.
- Same-cycle events: exactly one is acted on; priority clr > start > sel > inc; the others are dropped.
- SET:
  - sel event: sel=sel+1, wrapping 3->0.
  - inc event: selected digit +1 with wrap: a1, c1, d1 wrap 9->0; b1 wraps 5->0. Other digits unchanged.
  - clr event: all digits=0; sel=0.
  - start event with all digits 0: ignored, stays SET.
  - start event with any digit nonzero: ->RUN.
- RUN:
  - start event: ->PAUSE.
  - clr event: ->SET with digits unchanged, so the counter reloads the preset.
  - dn=1: ->DONE; dn outranks any event in the same cycle.
  - sel and inc events ignored.
- PAUSE:
  - str=0 and load=0, so the counter holds its value.
  - start: ->RUN.
  - clr: ->SET.
  - sel and inc ignored.
- DONE:
  - alarm=1.
  - Any clr or start event: ->SET and dn_clr=1 for that transition cycle only; digits retain the last preset.
  - sel and inc ignored.
- Outputs:
  - load, str and alarm are pure decodes of the registered state, glitch-free.
  - Digits and sel are registered.
- dn arriving in SET or PAUSE is ignored.
- Reset asserted mid-RUN or mid-DONE forces SET at once; alarm drops asynchronously.

Test Plan (DEBOUNCE_CYCLES=4):
- Bounce rejection: btn_inc toggles every 2 cycles for 20 cycles, then holds 1. Required: exactly one inc event; a1 0->1 about 6 cycles after the final rise.
- Digit wrap: sel=1, ten inc presses. Required: b1 sequence 1,2,3,4,5,0,1,2,3,4; a1, c1 and d1 stay 0. Then four sel presses return sel to 1.
- Start gating: all digits 0, press start. Required: state stays SET, load=1, str=0. Set a1=3, press start. Required: load=0, str=1 on the cycle after the event.
- Pause/resume: in RUN press start, then start again. Required: str 1->0->1, load stays 0 throughout, alarm=0.
- Completion: in RUN drive dn=1 in the same cycle as a start event. Required: DONE with alarm=1 and str=0. Then clr press gives one dn_clr pulse, load=1, digits unchanged.
- Async reset: assert reset=0 mid-RUN between clock edges. Required: str=0, load=1, digits 0 and sel 0 before the next rising edge.

Source files
------------

// File: rtl/timer_entry.sv
// Operator front-end for the egg-timer: debounces the four push-buttons, builds the
// BCD preset on a1..d1 and sequences the countdown counter through set/run/pause/done.
module timer_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       dn,
    output logic [3:0] a1,
    output logic [3:0] b1,
    output logic [3:0] c1,
    output logic [3:0] d1,
    output logic [1:0] sel,
    output logic       load,
    output logic       str,
    output logic       alarm,
    output logic       dn_clr
);

    localparam int unsigned NBTN = 4;
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // One-hot so load/str/alarm come straight off a flop with no decode glitch.
    localparam logic [3:0] ST_SET   = 4'b0001;
    localparam logic [3:0] ST_RUN   = 4'b0010;
    localparam logic [3:0] ST_PAUSE = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    // Button bit order: 0=sel, 1=inc, 2=start, 3=clr.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] ev;
    logic [CW-1:0]   cnt [NBTN];

    assign raw = {btn_clr, btn_start, btn_inc, btn_sel};

    // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            ev     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            ev    <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                        ev[i]     <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    logic ev_clr;
    logic ev_start;
    logic ev_sel;
    logic ev_inc;

    assign ev_clr   = ev[3];
    assign ev_start = ev[2] & ~ev[3];
    assign ev_sel   = ev[0] & ~(|ev[3:2]);
    assign ev_inc   = ev[1] & ~(|{ev[3:2], ev[0]});

    function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] top);
        bcd_inc = (v >= top) ? 4'd0 : v + 4'd1;
    endfunction

    logic [3:0] state;
    logic [3:0] state_n;
    logic [3:0] a_n;
    logic [3:0] b_n;
    logic [3:0] c_n;
    logic [3:0] d_n;
    logic [1:0] sel_n;
    logic       dn_clr_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_SET;
            a1     <= '0;
            b1     <= '0;
            c1     <= '0;
            d1     <= '0;
            sel    <= '0;
            dn_clr <= 1'b0;
        end else begin
            state  <= state_n;
            a1     <= a_n;
            b1     <= b_n;
            c1     <= c_n;
            d1     <= d_n;
            sel    <= sel_n;
            dn_clr <= dn_clr_n;
        end
    end

    // Next state and preset edits; one event at most is acted on per cycle.
    always_comb begin
        state_n  = state;
        a_n      = a1;
        b_n      = b1;
        c_n      = c1;
        d_n      = d1;
        sel_n    = sel;
        dn_clr_n = 1'b0;
        case (state)
            ST_SET: begin
                if (ev_clr) begin
                    a_n   = '0;
                    b_n   = '0;
                    c_n   = '0;
                    d_n   = '0;
                    sel_n = '0;
                end else if (ev_start) begin
                    if (|{a1, b1, c1, d1}) state_n = ST_RUN;
                end else if (ev_sel) begin
                    sel_n = sel + 2'd1;
                end else if (ev_inc) begin
                    case (sel)
                        2'd0: a_n = bcd_inc(a1, 4'd9);
                        2'd1: b_n = bcd_inc(b1, 4'd5);
                        2'd2: c_n = bcd_inc(c1, 4'd9);
                        2'd3: d_n = bcd_inc(d1, 4'd9);
                    endcase
                end
            end
            ST_RUN: begin
                if (dn)            state_n = ST_DONE;
                else if (ev_start) state_n = ST_PAUSE;
                else if (ev_clr)   state_n = ST_SET;
            end
            ST_PAUSE: begin
                if (ev_start)    state_n = ST_RUN;
                else if (ev_clr) state_n = ST_SET;
            end
            ST_DONE: begin
                if (ev_clr || ev_start) begin
                    state_n  = ST_SET;
                    dn_clr_n = 1'b1;
                end
            end
            default: state_n = ST_SET;
        endcase
    end

    assign load  = state[0];
    assign str   = state[1];
    assign alarm = state[3];

endmodule

// File: tb/tb_timer_entry.sv
// Directed bench for timer_entry with a short debounce window.
module tb_timer_entry;

    localparam int unsigned DB = 4;
    localparam int B_SEL   = 0;
    localparam int B_INC   = 1;
    localparam int B_START = 2;
    localparam int B_CLR   = 3;
    localparam logic [20:0] RST_SNAP = {16'h0000, 2'd0, 1'b1, 1'b0, 1'b0};

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn   = '0;
    logic       dn    = 1'b0;
    logic [3:0] a1, b1, c1, d1;
    logic [1:0] sel;
    logic       load, str, alarm, dn_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_sel  (btn[0]),
        .btn_inc  (btn[1]),
        .btn_start(btn[2]),
        .btn_clr  (btn[3]),
        .dn       (dn),
        .a1       (a1),
        .b1       (b1),
        .c1       (c1),
        .d1       (d1),
        .sel      (sel),
        .load     (load),
        .str      (str),
        .alarm    (alarm),
        .dn_clr   (dn_clr)
    );

    typedef struct {
        int         b;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int b, input int a, input int bb, input int c,
                                input int d, input int s, input bit ld, input bit st,
                                input bit al);
        vec_t v;
        v.b   = b;
        v.exp = {4'(a), 4'(bb), 4'(c), 4'(d), 2'(s), ld, st, al};
        return v;
    endfunction

    function automatic logic [20:0] snap();
        return {a1, b1, c1, d1, sel, load, str, alarm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        wait_neg(10);
        btn[b] = 1'b0;
        wait_neg(10);
    endtask

    task automatic hold_check(input int n, input logic exp_str);
        for (int k = 0; k < n; k++) begin
            wait_neg(1);
            check("hold_lsa", 32'({load, str, alarm}), 32'({1'b0, exp_str, 1'b0}));
        end
    endtask

    initial begin
        int bseq[10];
        bseq = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};

        vecs.push_back(mk(B_CLR,   0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_START, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_SEL,   0, 0, 0, 0, 1, 1, 0, 0));
        for (int k = 0; k < 10; k++) vecs.push_back(mk(B_INC, 0, bseq[k], 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(B_SEL,   0, 4, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(B_SEL,   0, 4, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(B_SEL,   0, 4, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_SEL,   0, 4, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(B_CLR,   0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_INC,   1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_INC,   2, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(B_INC,   3, 0, 0, 0, 0, 1, 0, 0));

        // Reset values
        #12;
        check("reset_snap", 32'(snap()), 32'(RST_SNAP));
        check("reset_dnclr", 32'(dn_clr), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        wait_neg(2);

        // Bounce rejection, then a clean rise
        for (int k = 0; k < 10; k++) begin
            btn[B_INC] = ~btn[B_INC];
            wait_neg(2);
            check("bounce_a1", 32'(a1), 32'(0));
        end
        btn[B_INC] = 1'b1;
        wait_neg(5);
        check("deb_early", 32'(a1), 32'(0));
        wait_neg(2);
        check("deb_event", 32'(a1), 32'(1));
        wait_neg(3);
        btn[B_INC] = 1'b0;
        wait_neg(12);
        check("deb_release", 32'(snap()), 32'({4'd1, 12'h000, 2'd0, 3'b100}));

        // Table of single presses in SET
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].b);
            check($sformatf("vec%0d", i), 32'(snap()), 32'(vecs[i].exp));
        end

        // Start with a nonzero preset: run begins the cycle after the event
        btn[B_START] = 1'b1;
        wait_neg(6);
        check("start_pre", 32'({load, str}), 32'(2'b10));
        wait_neg(1);
        check("start_run", 32'({load, str, alarm}), 32'(3'b010));
        wait_neg(3);
        btn[B_START] = 1'b0;
        hold_check(10, 1'b1);

        // Pause, dn ignored while paused, then resume
        btn[B_START] = 1'b1;
        wait_neg(7);
        check("pause", 32'({load, str, alarm}), 32'(3'b000));
        dn = 1'b1;
        wait_neg(2);
        dn = 1'b0;
        check("pause_dn", 32'({load, str, alarm}), 32'(3'b000));
        wait_neg(1);
        btn[B_START] = 1'b0;
        hold_check(10, 1'b0);
        btn[B_START] = 1'b1;
        wait_neg(7);
        check("resume", 32'({load, str, alarm}), 32'(3'b010));
        wait_neg(3);
        btn[B_START] = 1'b0;
        hold_check(10, 1'b1);

        // dn in the same cycle as a start event wins
        btn[B_START] = 1'b1;
        wait_neg(6);
        dn = 1'b1;
        wait_neg(1);
        dn = 1'b0;
        check("done", 32'({load, str, alarm, dn_clr}), 32'(4'b0010));
        wait_neg(3);
        btn[B_START] = 1'b0;
        wait_neg(10);
        check("done_hold", 32'({load, str, alarm}), 32'(3'b001));

        // Acknowledge with clr: single dn_clr pulse, preset kept
        btn[B_CLR] = 1'b1;
        wait_neg(7);
        check("ack", 32'({load, str, alarm, dn_clr}), 32'(4'b1001));
        check("ack_digits", 32'({a1, b1, c1, d1, sel}), 32'({16'h3000, 2'd0}));
        wait_neg(1);
        check("ack_pulse_end", 32'(dn_clr), 32'(0));
        wait_neg(2);
        btn[B_CLR] = 1'b0;
        wait_neg(10);

        // Asynchronous reset in the middle of RUN
        press(B_START);
        check("rerun", 32'({load, str, alarm}), 32'(3'b010));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", 32'(snap()), 32'(RST_SNAP));
        check("async_dnclr", 32'(dn_clr), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        wait_neg(2);
        check("post_reset", 32'(snap()), 32'(RST_SNAP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
